// File: rtl/mips_bus_access_unit.sv
// -----------------------------------------------------------------------------
// mips_bus_access_unit
//   Load/store sequencer between the MIPS core datapath and an Avalon-MM master
//   port. Takes one byte/half/word request, drives a single registered bus
//   transfer (held stable across waitrequest), and returns a big-endian,
//   sign/zero-extended load result. Misaligned or illegal requests are trapped
//   without any bus activity.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   start_i           request strobe, sampled only in IDLE
//   req_write_i       1 = store, 0 = load
//   req_size_i        00 byte, 01 half, 10 word, 11 illegal
//   req_signed_i      loads: 1 = sign-extend, 0 = zero-extend
//   req_addr_i        byte effective address
//   req_wdata_i       store value, sub-word value in the low bits
//   busy_o            high while not IDLE (core stall)
//   done_o            one-cycle completion pulse
//   error_o           valid with done_o: trapped request
//   load_data_o       extended load result, held between good loads
//   wait_cycles_o     saturating count of stalled ACCESS cycles
//   address/read/write/waitrequest/writedata/byteenable/readdata
//                     Avalon-MM master signals (little-endian byte lanes)
// -----------------------------------------------------------------------------
module mips_bus_access_unit #(
  parameter int WAIT_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic                      req_write_i,
  input  logic [1:0]                req_size_i,
  input  logic                      req_signed_i,
  input  logic [31:0]               req_addr_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [31:0]               load_data_o,
  output logic [WAIT_CNT_WIDTH-1:0] wait_cycles_o,
  output logic [31:0]               address,
  output logic                      read,
  output logic                      write,
  input  logic                      waitrequest,
  output logic [31:0]               writedata,
  output logic [3:0]                byteenable,
  input  logic [31:0]               readdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [31:0]               address_q;
  logic                      read_q, write_q;
  logic [3:0]                be_q;
  logic [31:0]               wdata_q;
  logic [1:0]                size_q;
  logic                      signed_q;
  logic [1:0]                off_q;
  logic [31:0]               load_q;
  logic                      error_q;
  logic [WAIT_CNT_WIDTH-1:0] wait_q;

  logic                      misaligned;
  logic [3:0]                be_new;
  logic [31:0]               wdata_new;
  logic [31:0]               lane_shifted;
  logic [15:0]               half_sel;
  logic [31:0]               load_ext;

  // Request decode: alignment trap plus byte-lane placement of store data.
  // The lowest address carries the most significant byte, so sub-words are
  // byte-swapped into little-endian Avalon lanes.
  // NOTE: every signal written in an always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    misaligned = 1'b0;
    be_new     = 4'b0000;
    wdata_new  = 32'h0;
    case (req_size_i)
      2'b00: begin
        be_new    = 4'b0001 << req_addr_i[1:0];
        wdata_new = {24'h0, req_wdata_i[7:0]} << {req_addr_i[1:0], 3'b000};
      end
      2'b01: begin
        misaligned = req_addr_i[0];
        if (req_addr_i[1]) begin
          be_new    = 4'b1100;
          wdata_new = {req_wdata_i[7:0], req_wdata_i[15:8], 16'h0};
        end else begin
          be_new    = 4'b0011;
          wdata_new = {16'h0, req_wdata_i[7:0], req_wdata_i[15:8]};
        end
      end
      2'b10: begin
        misaligned = (req_addr_i[1:0] != 2'b00);
        be_new     = 4'b1111;
        wdata_new  = {req_wdata_i[7:0], req_wdata_i[15:8],
                      req_wdata_i[23:16], req_wdata_i[31:24]};
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Load extraction from the captured lanes, then extension to 32 bits.
  always_comb begin
    lane_shifted = readdata >> {off_q, 3'b000};
    half_sel     = off_q[1] ? {readdata[23:16], readdata[31:24]}
                            : {readdata[7:0],   readdata[15:8]};
    load_ext     = 32'h0;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & lane_shifted[7]}}, lane_shifted[7:0]};
      2'b01:   load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_ext = {readdata[7:0], readdata[15:8],
                           readdata[23:16], readdata[31:24]};
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = misaligned ? S_DONE : S_ACCESS;
      S_ACCESS: if (!waitrequest) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      address_q <= 32'h0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'h0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      off_q     <= 2'b00;
      load_q    <= 32'h0;
      error_q   <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q <= state_d;
      error_q <= (state_q == S_IDLE) && start_i && misaligned;
      case (state_q)
        S_IDLE: begin
          if (start_i && !misaligned) begin
            address_q <= {req_addr_i[31:2], 2'b00};
            read_q    <= !req_write_i;
            write_q   <= req_write_i;
            be_q      <= be_new;
            wdata_q   <= wdata_new;
            size_q    <= req_size_i;
            signed_q  <= req_signed_i;
            off_q     <= req_addr_i[1:0];
          end
        end
        S_ACCESS: begin
          if (waitrequest) begin
            if (wait_q != '1) wait_q <= wait_q + WAIT_CNT_WIDTH'(1);
          end else begin
            // Transfer accepted: capture load data and release the bus.
            if (!write_q) load_q <= load_ext;
            address_q <= 32'h0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            be_q      <= 4'b0000;
            wdata_q   <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign error_o       = error_q;
  assign load_data_o   = load_q;
  assign wait_cycles_o = wait_q;
  assign address       = address_q;
  assign read          = read_q;
  assign write         = write_q;
  assign byteenable    = be_q;
  assign writedata     = wdata_q;

endmodule
